// File: rtl/status_pkg.sv
// Shared definitions for the status indicator: per-channel mode encodings.
package status_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_LEVEL   = 2'd0,
        MODE_STRETCH = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_HEART   = 2'd3
    } mode_e;

endpackage

// File: rtl/pulse_stretcher.sv
// One indicator channel: retriggerable stretch counter plus sticky event flag.
module pulse_stretcher #(
    parameter int W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic clear,
    output logic active,
    output logic sticky
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;

    // A strobe always reloads to full, so retriggers extend rather than accumulate.
    always_comb begin
        cnt_next = cnt;
        if (strobe)
            cnt_next = '1;
        else if (cnt != '0)
            cnt_next = cnt - ONE;
    end

    assign active = (cnt_next != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sticky <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            sticky <= strobe | (sticky & ~clear);
        end
    end

endmodule

// File: rtl/status_indicator.sv
// Multi-channel LED status indicator: heartbeat, per-channel mode mux and
// LED polarity; stretch/sticky state lives in pulse_stretcher instances.
module status_indicator
    import status_pkg::*;
#(
    parameter int NCHAN       = 8,
    parameter int STRETCHLOG2 = 24,
    parameter int HBLOG2      = 28,
    parameter int BLINKBIT    = 22,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCHAN-1:0]        Strobe,
    input  logic [NCHAN-1:0]        Level,
    input  logic [MODE_W*NCHAN-1:0] Mode,
    input  logic                    Clear,
    input  logic                    LampTest,
    output logic [NCHAN-1:0]        Leds,
    output logic [NCHAN-1:0]        Status,
    output logic [NCHAN-1:0]        Sticky,
    output logic                    Hb
);

    localparam logic              POL    = (ACTIVE_LOW != 0);
    localparam logic [HBLOG2-1:0] HB_ONE = {{(HBLOG2-1){1'b0}}, 1'b1};

    logic [HBLOG2-1:0] hb_cnt;
    logic [HBLOG2-1:0] hb_next;
    logic [NCHAN-1:0]  active;
    logic [NCHAN-1:0]  status_next;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        pulse_stretcher #(.W(STRETCHLOG2)) u_stretch (
            .clk    (clk),
            .rst    (rst),
            .strobe (Strobe[g]),
            .clear  (Clear),
            .active (active[g]),
            .sticky (Sticky[g])
        );
    end

    assign hb_next = hb_cnt + HB_ONE;
    assign Hb      = hb_cnt[HBLOG2-1];

    // Mode mux works on next-state values so registered Status lines up with Hb.
    always_comb begin
        status_next = '0;
        for (int unsigned i = 0; i < NCHAN; i++) begin
            case (mode_e'(Mode[i*MODE_W +: MODE_W]))
                MODE_LEVEL:   status_next[i] = Level[i];
                MODE_STRETCH: status_next[i] = active[i];
                MODE_BLINK:   status_next[i] = active[i] & hb_next[BLINKBIT];
                MODE_HEART:   status_next[i] = hb_next[HBLOG2-1];
                default:      status_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt <= '1;
            Status <= '0;
            Leds   <= {NCHAN{POL}};
        end else begin
            hb_cnt <= hb_next;
            Status <= status_next;
            Leds   <= (status_next | {NCHAN{LampTest}}) ^ {NCHAN{POL}};
        end
    end

endmodule

// File: tb/tb_status_indicator.sv
// Directed self-checking bench for status_indicator (4 channels, short counters).
module tb_status_indicator;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Strobe;
    logic [3:0] Level;
    logic [7:0] Mode;
    logic       Clear;
    logic       LampTest;
    logic [3:0] Leds;
    logic [3:0] Status;
    logic [3:0] Sticky;
    logic       Hb;

    int checks = 0;
    int errors = 0;
    logic [5:0] tb_hb = '1;

    status_indicator #(
        .NCHAN(4), .STRETCHLOG2(4), .HBLOG2(6), .BLINKBIT(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .Strobe(Strobe), .Level(Level), .Mode(Mode),
        .Clear(Clear), .LampTest(LampTest), .Leds(Leds), .Status(Status),
        .Sticky(Sticky), .Hb(Hb)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Advance one clock; independent heartbeat model tracks the expected counter.
    task automatic step();
        @(posedge clk);
        if (rst) tb_hb = '1;
        else     tb_hb = tb_hb + 6'd1;
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; Strobe = 4'b1111; Level = 4'b1111; Mode = 8'h55;
        Clear = 1'b1; LampTest = 1'b1;
        repeat (3) step();
        chk("reset_leds",   Leds,   4'b1111);
        chk("reset_status", Status, 4'b0000);
        chk("reset_sticky", Sticky, 4'b0000);
        chk("reset_hb",     {3'b0, Hb}, 4'd1);
        Strobe = '0; Level = '0; Mode = '0; Clear = 1'b0; LampTest = 1'b0;
        rst = 1'b0;
        step();
        chk("release_hb0", {3'b0, Hb}, 4'd0);
        chk("release_status", Status, 4'b0000);
        repeat (31) step();
        chk("hb_before_32", {3'b0, Hb}, 4'd0);
        step();
        chk("hb_after_32", {3'b0, Hb}, 4'd1);
        chk("hb_model", {3'b0, Hb}, {3'b0, tb_hb[5]});
    endtask

    task automatic test_stretch();
        Mode = 8'b0000_0001;
        Strobe = 4'b0001;
        step();
        Strobe = '0;
        for (int n = 0; n < 15; n++) begin
            if (n > 0) step();
            chk("stretch_status", Status, 4'b0001);
            chk("stretch_leds",   Leds,   4'b1110);
        end
        step();
        chk("stretch_end_status", Status, 4'b0000);
        chk("stretch_end_leds",   Leds,   4'b1111);
    endtask

    task automatic test_retrigger();
        Mode = 8'b0000_0001;
        for (int n = 0; n < 25; n++) begin
            Strobe = (n == 0 || n == 10) ? 4'b0001 : 4'b0000;
            step();
            chk("retrig_status", Status, 4'b0001);
        end
        Strobe = '0;
        step();
        chk("retrig_end", Status, 4'b0000);
    endtask

    task automatic test_blink();
        Mode = 8'b0000_1000;
        Strobe = 4'b0010;
        for (int n = 0; n < 20; n++) begin
            step();
            Strobe = '0;
            chk("blink_status", Status, {2'b00, (n < 15) && tb_hb[2], 1'b0});
        end
    endtask

    task automatic test_level_heart();
        Mode = 8'b1100_0000;
        Level = 4'b0100;
        step();
        chk("level_heart_a", Status, {tb_hb[5], 3'b100});
        Level = 4'b0000;
        for (int n = 0; n < 40; n++) begin
            step();
            chk("level_heart_b", Status, {tb_hb[5], 3'b000});
            chk("heart_eq_hb", {3'b0, Status[3]}, {3'b0, Hb});
        end
    endtask

    task automatic test_back_to_back();
        Mode = 8'h55;
        Strobe = 4'b1111;
        step();
        Strobe = '0;
        chk("multi_start", Status, 4'b1111);
        repeat (14) step();
        chk("multi_last", Status, 4'b1111);
        step();
        chk("multi_end", Status, 4'b0000);
    endtask

    task automatic test_sticky_lamp();
        Mode = 8'h00; Level = 4'b0101;
        Clear = 1'b1; Strobe = 4'b0100;
        step();
        chk("sticky_clear_and_strobe", Sticky, 4'b0100);
        Strobe = '0;
        step();
        chk("sticky_clear_alone", Sticky, 4'b0000);
        Clear = 1'b0;
        step();
        chk("lamp_pre_leds", Leds, 4'b1010);
        LampTest = 1'b1;
        step();
        chk("lamp_leds",   Leds,   4'b0000);
        chk("lamp_status", Status, 4'b0101);
        chk("lamp_sticky", Sticky, 4'b0000);
        LampTest = 1'b0;
        step();
        chk("lamp_off_leds", Leds, 4'b1010);
    endtask

    task automatic test_reset_abort();
        Mode = 8'b0000_0001; Level = '0;
        Strobe = 4'b0001;
        step();
        Strobe = '0;
        repeat (3) step();
        chk("abort_pre", Status, 4'b0001);
        rst = 1'b1; Strobe = 4'b0001; LampTest = 1'b1;
        step();
        chk("abort_rst_status", Status, 4'b0000);
        chk("abort_rst_sticky", Sticky, 4'b0000);
        chk("abort_rst_leds",   Leds,   4'b1111);
        chk("abort_rst_hb",     {3'b0, Hb}, 4'd1);
        rst = 1'b0; Strobe = '0; LampTest = 1'b0;
        step();
        chk("abort_post_status", Status, 4'b0000);
        chk("abort_post_hb",     {3'b0, Hb}, 4'd0);
    endtask

    initial begin
        test_reset();
        test_stretch();
        test_retrigger();
        test_blink();
        test_level_heart();
        test_back_to_back();
        test_sticky_lamp();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_indicator.md
STATUS_INDICATOR -- requirements
Module: status_indicator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all outputs SHALL be registered on clk.
REQ-002 Parameter NCHAN, default 8: number of indicator channels, 1..16.
REQ-003 Parameter STRETCHLOG2, default 24: width of each channel's stretch counter, 2..28.
REQ-004 Parameter HBLOG2, default 28: width of the heartbeat counter, 4..32.
REQ-005 Parameter BLINKBIT, default 22: heartbeat counter bit used as blink phase, less than HBLOG2.
REQ-006 Parameter ACTIVE_LOW, default 1: 1 means Leds drive 0 to light.
REQ-007 clk  in  1  system clock, 192 MHz PLL output.
REQ-008 rst  in  1  synchronous active-high reset; topLevel drives it with (!rstfpga || !lock).
REQ-009 Strobe  in  NCHAN  single-cycle event pulses (overflow, frame received, tx activity), synchronous to clk.
REQ-010 Level  in  NCHAN  static state inputs (sync status, phase inversion).
REQ-011 Mode  in  2*NCHAN  per-channel mode; bits [2i+1:2i] belong to channel i.
REQ-012 Clear  in  1  clears all Sticky bits.
REQ-013 LampTest  in  1  forces every LED on.
REQ-014 Leds  out  NCHAN  pin-level LED drive, polarity set by ACTIVE_LOW.
REQ-015 Status  out  NCHAN  active-high logical indication; frameToSerial/frameToSPI use it as the Leds stats byte.
REQ-016 Sticky  out  NCHAN  latched "event seen since Clear" flags.
REQ-017 Hb  out  1  heartbeat, MSB of the heartbeat counter.

Function
REQ-018 Mode encodings: LEVEL=0, STRETCH=1, BLINK=2, HEART=3.
REQ-019 Heartbeat counter: increments by 1 every cycle and wraps modulo 2^HBLOG2; Hb = its MSB.
REQ-020 Each channel's stretch counter: loads 2^STRETCHLOG2-1 in the cycle Strobe[i] is sampled high, whatever the mode; otherwise decrements when nonzero; holds at 0.
REQ-021 A Strobe that arrives while the counter is nonzero SHALL reload it to full (retrigger), never add or wrap.
REQ-022 Channel active = (next-state stretch counter != 0).
REQ-023 LEVEL: Status[i] follows Level[i] with 1-cycle latency.
REQ-024 STRETCH: Status[i] rises on the edge after Strobe[i] is sampled and stays high for exactly 2^STRETCHLOG2-1 cycles after the last strobe.
REQ-025 BLINK: Status[i] = active AND heartbeat bit BLINKBIT; it is low when the channel is not active.
REQ-026 HEART: Status[i] = Hb.
REQ-027 The stretch counter keeps running across Mode changes; switching into STRETCH shows only the remaining count, and nothing restarts.
REQ-028 Sticky[i] sets on Strobe[i] and clears on Clear; when Clear and Strobe[i] occur together, Sticky[i] ends set.
REQ-029 Leds[i] = (LampTest OR Status[i]) XOR ACTIVE_LOW, registered, so Leds lag Status by 0 cycles and follow LampTest with 1-cycle latency.
REQ-030 LampTest SHALL NOT alter Status, Sticky or any counter.
REQ-031 Channels are independent: simultaneous strobes on any subset SHALL each be handled in the same cycle.

Reset
REQ-032 While rst is high: stretch counters = 0, Status = 0, Sticky = 0, Leds = all ACTIVE_LOW (all off), heartbeat counter = all ones (so Hb = 1).
REQ-033 Rst SHALL win over Strobe, Clear and LampTest in the same cycle; a reset in mid-stretch SHALL abort the stretch.
REQ-034 In the first cycle after reset is released, the heartbeat counter SHALL be 0.

Structure
REQ-035 The mode encodings (REQ-018) and the mode field width SHALL live in the shared package status_pkg.
REQ-036 The per-channel stretch counter plus sticky bit SHALL be the sub-module pulse_stretcher, instantiated NCHAN times with a generate loop.
REQ-037 The heartbeat counter, mode multiplexing and LED polarity logic SHALL stay in status_indicator.

Verification (NCHAN=4, STRETCHLOG2=4, HBLOG2=6, BLINKBIT=2, ACTIVE_LOW=1)
REQ-038 Reset, then release -> Leds=4'b1111, Status=0, Sticky=0, Hb=1 during reset; Hb=0 in the first cycle after release; Hb=1 again after 32 cycles.
REQ-039 Mode0=STRETCH, a 1-cycle Strobe[0] -> Status[0] high for exactly 15 cycles starting the next cycle, and Leds[0]=0 over the same window.
REQ-040 Strobe[0] again 10 cycles into a stretch -> Status[0] stays high for 15 cycles after the second strobe, 25 cycles in total, with no gap.
REQ-041 Mode1=BLINK, Strobe[1] -> Status[1] toggles every 4 cycles in phase with heartbeat bit 2 and is low once 15 cycles have passed.
REQ-042 Clear and Strobe[2] in the same cycle -> Sticky[2]=1; Clear alone one cycle later -> Sticky[2]=0; LampTest=1 -> Leds=4'b0000 one cycle later with Status unchanged.
